// File: rtl/mux_select_sequencer_pkg.sv
// rtl/mux_select_sequencer_pkg.sv - shared state encoding, select geometry and one-hot helper
package mux_select_sequencer_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SCAN = 1'b1;
    localparam int   SEL_W   = 2;
    localparam int   NPOS    = 4;

    localparam logic [SEL_W-1:0] LAST_POS = SEL_W'(NPOS - 1);

    typedef enum logic {
        IDLE = ST_IDLE,
        SCAN = ST_SCAN
    } state_t;

    function automatic logic [NPOS-1:0] pos_onehot(input logic [SEL_W-1:0] pos);
        return NPOS'(1) << pos;
    endfunction

endpackage

// File: rtl/mux_select_sequencer_dwell_timer.sv
// rtl/mux_select_sequencer_dwell_timer.sv - dwell counter with clear/enable and terminal count at DWELL-1
module dwell_timer #(
    parameter int DWELL = 1,
    parameter int CW    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] TC_VAL = CW'(DWELL - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - 4-position select scanner feeding the 4:1 mux / 2-to-4 decoder (option: SCAN_LOOP_EN)
module mux_select_sequencer
    import mux_select_sequencer_pkg::*;
#(
    parameter int DWELL = 1,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [3:0] data_in,
    output logic       s0,
    output logic       s1,
    output logic [3:0] sel_onehot,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       busy,
    output logic       done
);

    state_t            state;
    logic [SEL_W-1:0]  sel;
    logic [NPOS-1:0]   word;
    logic              done_r;
    logic              tc;
    logic              scanning;

    assign scanning = (state == SCAN);

    // Counter is held clear in IDLE so every scan starts from a fresh dwell.
    dwell_timer #(
        .DWELL (DWELL),
        .CW    (CW)
    ) u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!scanning || tc),
        .en    (scanning),
        .tc    (tc)
    );

`ifdef SCAN_LOOP_EN
    assign load_ready = !scanning || (sel == LAST_POS && tc);
`else
    assign load_ready = !scanning;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= '0;
            word   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        word  <= data_in;
                        sel   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (tc) begin
                        if (sel != LAST_POS) begin
                            sel <= sel + SEL_W'(1);
                        end else begin
                            sel    <= '0;
                            done_r <= 1'b1;
`ifdef SCAN_LOOP_EN
                            if (load_valid) begin
                                word <= data_in;
                            end
`else
                            state <= IDLE;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s0         = sel[0];
    assign s1         = sel[1];
    assign sel_onehot = scanning ? pos_onehot(sel) : '0;
    assign bit_out    = scanning & word[sel];
    assign bit_valid  = scanning;
    assign busy       = scanning;
    assign done       = done_r;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb/tb_mux_select_sequencer.sv - directed table-driven bench; instances at DWELL=1,2,3 share one clock
module tb_mux_select_sequencer;

    typedef struct {
        int         inst;
        logic [3:0] data;
        int         len;
        logic [11:0] bits;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid [3];
    logic [3:0] data_in    [3];
    logic       load_ready [3];
    logic       s0         [3];
    logic       s1         [3];
    logic [3:0] sel_onehot [3];
    logic       bit_out    [3];
    logic       bit_valid  [3];
    logic       busy       [3];
    logic       done       [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        mux_select_sequencer #(
            .DWELL (k + 1),
            .CW    (8)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .load_valid (load_valid[k]),
            .load_ready (load_ready[k]),
            .data_in    (data_in[k]),
            .s0         (s0[k]),
            .s1         (s1[k]),
            .sel_onehot (sel_onehot[k]),
            .bit_out    (bit_out[k]),
            .bit_valid  (bit_valid[k]),
            .busy       (busy[k]),
            .done       (done[k])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input int k, input string tag);
        chk($sformatf("%s_ready_i%0d", tag, k), load_ready[k], 1);
        chk($sformatf("%s_sel_i%0d", tag, k), {s1[k], s0[k]}, 0);
        chk($sformatf("%s_onehot_i%0d", tag, k), sel_onehot[k], 0);
        chk($sformatf("%s_bit_i%0d", tag, k), bit_out[k], 0);
        chk($sformatf("%s_valid_i%0d", tag, k), bit_valid[k], 0);
        chk($sformatf("%s_busy_i%0d", tag, k), busy[k], 0);
        chk($sformatf("%s_done_i%0d", tag, k), done[k], 0);
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (!(load_ready[k] && !busy[k] && !done[k]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_timeout_i%0d", k), (n < 50), 1);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int k;
        int d;
        int pos;
        k = v.inst;
        d = v.inst + 1;
        @(negedge clk);
        load_valid[k] = 1'b1;
        data_in[k]    = v.data;
        chk($sformatf("v%0d_ready_pre", id), load_ready[k], 1);
        @(posedge clk);
        #1;
        load_valid[k] = 1'b0;
        data_in[k]    = ~v.data;
        for (int c = 0; c < v.len; c++) begin
            @(negedge clk);
            pos = c / d;
            chk($sformatf("v%0d_bit_c%0d", id, c), bit_out[k], v.bits[v.len-1-c]);
            chk($sformatf("v%0d_valid_c%0d", id, c), {bit_valid[k], busy[k]}, 2'b11);
            chk($sformatf("v%0d_sel_c%0d", id, c), {s1[k], s0[k]}, pos);
            chk($sformatf("v%0d_onehot_c%0d", id, c), sel_onehot[k], 1 << pos);
            chk($sformatf("v%0d_done_c%0d", id, c), done[k], 0);
            chk($sformatf("v%0d_ready_c%0d", id, c), load_ready[k], 0);
            data_in[k] = data_in[k] ^ 4'b0101;
        end
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", id), done[k], 1);
        chk($sformatf("v%0d_ready_done", id), load_ready[k], 1);
        chk($sformatf("v%0d_valid_done", id), bit_valid[k], 0);
        chk($sformatf("v%0d_onehot_done", id), sel_onehot[k], 0);
        @(negedge clk);
        chk($sformatf("v%0d_done_single", id), done[k], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        vec_t tail;
        logic [9:0] ev;
        logic [9:0] eb;
        logic [9:0] ed;
        logic [3:0] lw;
        int dcnt;

        vecs[0] = '{0, 4'b1011, 4,  12'b1101};
        vecs[1] = '{2, 4'b0110, 12, 12'b000111111000};
        vecs[2] = '{1, 4'b1001, 8,  12'b11000011};
        vecs[3] = '{0, 4'b0000, 4,  12'b0000};
        vecs[4] = '{0, 4'b1111, 4,  12'b1111};
        vecs[5] = '{2, 4'b1010, 12, 12'b000111000111};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load_valid[k] = 1'b1;
            data_in[k]    = 4'b1111;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_reset_vals(k, "rst");
        rst_n         = 1'b1;
        load_valid[1] = 1'b0;
        load_valid[2] = 1'b0;
        @(posedge clk);
        #1;
        load_valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_first_accept_valid", bit_valid[0], 1);
        chk("rst_first_accept_bit", bit_out[0], 1);

`ifdef SCAN_LOOP_EN
        repeat (4) @(posedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lw = 4'b0101;
        @(negedge clk);
        load_valid[0] = 1'b1;
        data_in[0]    = lw;
        @(posedge clk);
        #1;
        load_valid[0] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("loop_bit_c%0d", c), bit_out[0], lw[c % 4]);
            chk($sformatf("loop_valid_c%0d", c), bit_valid[0], 1);
            chk($sformatf("loop_done_c%0d", c), done[0], (c % 4 == 0 && c > 0));
            chk($sformatf("loop_ready_c%0d", c), load_ready[0], (c % 4 == 3));
        end
        load_valid[0] = 1'b1;
        data_in[0]    = 4'b0011;
        @(posedge clk);
        #1;
        load_valid[0] = 1'b0;
        lw = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("reload_bit_c%0d", c), bit_out[0], lw[c]);
            chk($sformatf("reload_valid_c%0d", c), bit_valid[0], 1);
            chk($sformatf("reload_done_c%0d", c), done[0], (c == 0));
        end
`else
        wait_idle(0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Back-to-back: second word is captured in the done cycle.
        ev = 10'b1111011110;
        eb = 10'b0001010000;
        ed = 10'b0000100001;
        dcnt = 0;
        @(negedge clk);
        load_valid[0] = 1'b1;
        data_in[0]    = 4'b1000;
        @(posedge clk);
        #1;
        data_in[0] = 4'b0001;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c < 10) begin
                chk($sformatf("b2b_valid_c%0d", c), bit_valid[0], ev[9-c]);
                chk($sformatf("b2b_bit_c%0d", c), bit_out[0], eb[9-c]);
                chk($sformatf("b2b_done_c%0d", c), done[0], ed[9-c]);
            end
            if (c == 4) chk("b2b_ready_done", load_ready[0], 1);
            if (done[0]) dcnt++;
            if (c == 5) load_valid[0] = 1'b0;
        end
        chk("b2b_done_count", dcnt, 2);

        // Mid-scan reset on the DWELL=2 instance.
        @(negedge clk);
        load_valid[1] = 1'b1;
        data_in[1]    = 4'b1111;
        @(posedge clk);
        #1;
        load_valid[1] = 1'b0;
        @(negedge clk);
        chk("mid_busy_c1", busy[1], 1);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals(1, "mid_async");
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done[1] || busy[1]) dcnt++;
        end
        chk("mid_no_done", dcnt, 0);
        tail = '{1, 4'b0110, 8, 12'b00111100};
        run_vec(tail, 6);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
